// File: rtl/tohost_monitor.sv
// tohost_monitor
//   Memory-mapped responder on the core store path that ends riscv-tests
//   self-checking programs. Decodes the tohost pass/fail encoding and runs a
//   watchdog cycle counter, so the verdict is available without probing the
//   core's internal state.
//
//   Register window (16 bytes at BASE_ADDR, word selected by addr[3:2]):
//     0x0 TOHOST  r/w, byte-lane merged
//     0x4 CYCLES  ro, watchdog count
//     0x8 STATUS  ro, {29'b0, timeout, pass, done}
//     0xC         reads 0, writes ignored
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     wr_en, rd_en    store / load request, sampled every edge
//     addr            byte address
//     wdata, wstrb    lane-aligned store data and byte enables
//     rdata, rvalid   registered load data, valid one cycle after rd_en
//     done, pass      test finished / passed (pass meaningful while done=1)
//     timeout         watchdog expired
//     fail_id         failing test number (tohost>>1), 0 unless failed
module tohost_monitor #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_id
);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [31:0] tohost, cycles, merged, rd_word;
  logic        hit, tohost_wr;
  logic [1:0]  word_sel;

  // Byte offset within a word does not select a register; the lanes are
  // already carried by wstrb.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign word_sel = addr[3:2];

  always_comb begin
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = wstrb[k] ? wdata[8*k +: 8] : tohost[8*k +: 8];
  end

  // Stores only land while the test is still running; terminal states
  // keep the value that ended the test.
  assign tohost_wr = wr_en && hit && (word_sel == 2'd0) && (state == RUN);

  // Next state: a completing write outranks the watchdog on the same edge.
  always_comb begin
    state_next = state;
    if (state == RUN) begin
      if (tohost_wr && merged[0]) begin
        state_next = (merged == 32'd1) ? PASS : FAIL;
      end else if (cycles == LIMIT) begin
        state_next = TIMEOUT;
      end
    end
  end

  assign done    = (state != RUN);
  assign pass    = (state == PASS);
  assign timeout = (state == TIMEOUT);

  always_comb begin
    rd_word = 32'd0;
    if (hit) begin
      case (word_sel)
        2'd0:    rd_word = tohost;
        2'd1:    rd_word = cycles;
        2'd2:    rd_word = {29'd0, timeout, pass, done};
        default: rd_word = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      tohost  <= 32'd0;
      cycles  <= 32'd0;
      fail_id <= 31'd0;
      rdata   <= 32'd0;
      rvalid  <= 1'b0;
    end else begin
      state  <= state_next;
      rvalid <= rd_en;
      // Read mux sees pre-write tohost, so a same-edge read returns the old value.
      if (rd_en)
        rdata <= rd_word;
      if (tohost_wr)
        tohost <= merged;
      // Count only edges that leave us in RUN: the count freezes at the
      // value that tripped the watchdog (or preceded the completing write).
      if (state == RUN && state_next == RUN)
        cycles <= cycles + 32'd1;
      if (state == RUN && state_next == FAIL)
        fail_id <= merged[31:1];
    end
  end

endmodule

// File: tb/tb_tohost_monitor.sv
module tb_tohost_monitor;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] rdata;
  logic        rvalid, done, pass, timeout;
  logic [30:0] fail_id;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  tohost_monitor #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(20)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .rvalid(rvalid),
    .done(done), .pass(pass), .timeout(timeout), .fail_id(fail_id)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    wr_en = 1'b0; wstrb = 4'd0;
  endtask

  // Expected load data goes on the scoreboard when the read is issued.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; rd_en = 1'b1; addr = BASE; wdata = 32'd1; wstrb = 4'hF;
    do_reset(2);
    wr_en = 1'b0; rd_en = 1'b0; wstrb = 4'd0;
    checks++;
    if ({done, pass, timeout, rvalid} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, timeout, rvalid});
    end
    checks++;
    if (fail_id !== 31'd0 || rdata !== 32'd0) begin
      failures++; $display("FAIL reset_data fail_id=%h rdata=%h exp=0", fail_id, rdata);
    end
    rd(BASE + 32'h4, 32'd0);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL reset_cycles rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE, 32'd0);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL reset_tohost rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_pass();
    do_reset(2);
    sw(BASE, 32'd1, 4'hF);
    checks++;
    if ({done, pass, timeout} !== 3'b110 || fail_id !== 31'd0) begin
      failures++; $display("FAIL pass_path dpt=%b fail_id=%h exp=110/0", {done, pass, timeout}, fail_id);
    end
    rd(BASE + 32'h8, 32'h3);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL pass_status rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_fail();
    do_reset(2);
    sw(BASE, 32'h7, 4'hF);
    checks++;
    if ({done, pass} !== 2'b10 || fail_id !== 31'd3) begin
      failures++; $display("FAIL fail_path dp=%b fail_id=%h exp=10/3", {done, pass}, fail_id);
    end
    sw(BASE, 32'h1, 4'hF);
    checks++;
    if ({done, pass} !== 2'b10 || fail_id !== 31'd3) begin
      failures++; $display("FAIL fail_sticky dp=%b fail_id=%h exp=10/3", {done, pass}, fail_id);
    end
    rd(BASE, 32'h7);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL fail_tohost rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE + 32'h8, 32'h1);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL fail_status rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_byte_merge();
    do_reset(1);
    sw(BASE + 32'h1, 32'h0000_AB00, 4'b0010);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL merge_run done=%b exp=0", done);
    end
    rd(BASE, 32'h0000_AB00);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL merge_lane1 rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    sw(BASE, 32'h0000_0001, 4'b0001);
    checks++;
    if ({done, pass} !== 2'b10 || fail_id !== 31'h5580) begin
      failures++; $display("FAIL merge_fail dp=%b fail_id=%h exp=10/5580", {done, pass}, fail_id);
    end
    rd(BASE, 32'h0000_AB01);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL merge_lane0 rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_ignored_writes();
    do_reset(1);
    sw(BASE, 32'h2, 4'hF);          // even nonzero: stored only
    sw(BASE, 32'h1, 4'h0);          // no lanes: unchanged even value
    sw(BASE + 32'h10, 32'h1, 4'hF); // outside window
    sw(BASE + 32'h4, 32'h1, 4'hF);  // read-only register
    sw(BASE + 32'hC, 32'h1, 4'hF);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL ignored_run done=%b exp=0", done);
    end
    rd(BASE, 32'h2);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL ignored_tohost rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_read_path();
    do_reset(1);
    repeat (3) tick();
    rd(BASE + 32'h4, 32'd3);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_cycles rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE + 32'h4, 32'd4);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_back_to_back rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE + 32'hC, 32'd0);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_reserved rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(32'h0000_2000, 32'd0);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_miss rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL rd_rvalid_drop rvalid=%b exp=0", rvalid);
    end
    // Read and write TOHOST on the same edge: read sees the old value.
    sb.push_back(32'd0);
    rd_en = 1'b1; wr_en = 1'b1; addr = BASE; wdata = 32'h4; wstrb = 4'hF;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wstrb = 4'd0;
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_same_edge rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE, 32'h4);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rd_after_write rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
  endtask

  task automatic test_watchdog();
    do_reset(1);
    repeat (19) tick();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL wd_early done=%b exp=0", done);
    end
    tick();
    checks++;
    if ({done, pass, timeout} !== 3'b101 || fail_id !== 31'd0) begin
      failures++; $display("FAIL wd_fire dpt=%b fail_id=%h exp=101/0", {done, pass, timeout}, fail_id);
    end
    rd(BASE + 32'h4, 32'd19);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL wd_cycles_frozen rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    rd(BASE + 32'h8, 32'h5);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL wd_status rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    sw(BASE, 32'h1, 4'hF);
    checks++;
    if ({done, pass, timeout} !== 3'b101) begin
      failures++; $display("FAIL wd_sticky dpt=%b exp=101", {done, pass, timeout});
    end
  endtask

  task automatic test_race();
    do_reset(1);
    repeat (19) tick();
    sw(BASE, 32'h1, 4'hF);
    checks++;
    if ({done, pass, timeout} !== 3'b110) begin
      failures++; $display("FAIL race_write_wins dpt=%b exp=110", {done, pass, timeout});
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    sw(BASE, 32'h7, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({done, pass, timeout} !== 3'b000 || fail_id !== 31'd0) begin
      failures++; $display("FAIL rst_mid dpt=%b fail_id=%h exp=000/0", {done, pass, timeout}, fail_id);
    end
    rd(BASE + 32'h4, 32'd0);
    checks++; e = sb.pop_front();
    if (rvalid !== 1'b1 || rdata !== e) begin
      failures++; $display("FAIL rst_mid_cycles rvalid=%b rdata=%h exp=%h", rvalid, rdata, e);
    end
    sw(BASE, 32'h1, 4'hF);
    checks++;
    if ({done, pass} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_pass dp=%b exp=11", {done, pass});
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_byte_merge();
    test_ignored_writes();
    test_read_path();
    test_watchdog();
    test_race();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout time=%0t limit=100000", $time);
    $fatal(1, "bench time limit");
  end

endmodule
